// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window generator and the CE.
package conv_pkg;

  // Output growth bits shared with the CE so both blocks size results identically.
  localparam int unsigned E1 = 1;
  localparam int unsigned E2 = 8;

  function automatic bit kernel_legal(input int unsigned k);
    return (k == 1) || (k == 3) || (k == 5) || (k == 7);
  endfunction

  function automatic int unsigned win_idx(input int unsigned ch, input int unsigned r,
                                          input int unsigned c, input int unsigned k);
    return ch * k * k + r * k + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: circular RAM whose output is the sample written DEPTH accepts ago.
module line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 56
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  // Read-before-write at the same slot yields exactly DEPTH cycles of delay.
  assign d_out = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[ptr] <= d_in;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KERNEL x KERNEL x CL_IN window generator feeding the CE, stride 1, no padding.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned CL_IN  = 14,
  parameter int unsigned KERNEL = 7,
  parameter int unsigned N      = 4,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CL_IN*N-1:0]               d_in,
  input  logic                             en_in,
  input  logic                             sof,
  output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
  output logic                             en_out,
  output logic                             last_out
);

  localparam int unsigned PIX_W = CL_IN * N;
  localparam int unsigned WIN_W = CL_IN * KERNEL * KERNEL * N;
  localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  if (!kernel_legal(KERNEL)) begin : g_bad_kernel
    $error("conv_window_gen: KERNEL must be 1, 3, 5 or 7");
  end
  if ((IMG_W < KERNEL) || (IMG_H < KERNEL)) begin : g_bad_image
    $error("conv_window_gen: image smaller than kernel");
  end

  logic             accept;
  logic [CW-1:0]    col, col_eff, col_nxt;
  logic [RW-1:0]    row, row_eff, row_nxt;
  logic             win_valid, win_last;

  assign accept = en_in && !rst;

  // Position of the pixel being accepted (sof forces origin) and of the one after it.
  always_comb begin
    col_eff  = sof ? '0 : col;
    row_eff  = sof ? '0 : row;
    col_nxt  = col_eff + CW'(1);
    row_nxt  = row_eff;
    if (col_eff == CW'(IMG_W - 1)) begin
      col_nxt = '0;
      row_nxt = (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
    end
    win_last = (row_eff == RW'(IMG_H - 1)) && (col_eff == CW'(IMG_W - 1));
  end

  if (KERNEL == 1) begin : g_valid_all
    assign win_valid = 1'b1;
  end else begin : g_valid_edge
    assign win_valid = (row_eff >= RW'(KERNEL - 1)) && (col_eff >= CW'(KERNEL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (en_in) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // chain[k] is the pixel k rows above the incoming one at the same column.
  logic [PIX_W-1:0] chain [KERNEL];
  assign chain[0] = d_in;

  for (genvar k = 0; k < KERNEL - 1; k++) begin : g_lb
    line_buffer #(
      .DEPTH(IMG_W),
      .WIDTH(PIX_W)
    ) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (en_in),
      .d_in (chain[k]),
      .d_out(chain[k+1])
    );
  end

  logic [PIX_W-1:0] win     [KERNEL][KERNEL];
  logic [PIX_W-1:0] win_nxt [KERNEL][KERNEL];
  logic [WIN_W-1:0] win_flat;

  // Shift every row left; the new right column is oldest row on top, d_in at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < int'(KERNEL) - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][KERNEL-1] = chain[KERNEL-1-r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned ch = 0; ch < CL_IN; ch++) begin
      for (int unsigned r = 0; r < KERNEL; r++) begin
        for (int unsigned c = 0; c < KERNEL; c++) begin
          win_flat[win_idx(ch, r, c, KERNEL)*N +: N] = win_nxt[r][c][ch*N +: N];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data2conv <= '0;
      en_out    <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      en_out   <= en_in && win_valid;
      last_out <= en_in && win_valid && win_last;
      if (en_in && win_valid) begin
        data2conv <= win_flat;
      end
    end
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator that sits directly upstream of the convolution element `CE`. It accepts a raster-ordered pixel stream, one pixel per accepted cycle, with all `CL_IN` channels of that pixel in parallel. It holds `KERNEL-1` previous image rows in line buffers and emits every valid `KERNEL`×`KERNEL`×`CL_IN` window (stride 1, no padding) as a flat `data2conv` vector with `en_out`. Both outputs connect straight to `CE.data2conv` and `CE.en_in`.

## Interface
- `CL_IN`, 14: input channels per pixel.
- `KERNEL`, 7: window size; legal values 1/3/5/7.
- `N`, 4: data width per channel sample.
- `IMG_W`, 28: image width in pixels; must be ≥ `KERNEL`.
- `IMG_H`, 28: image height in pixels; must be ≥ `KERNEL`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_in`  in  `CL_IN*N`  one pixel; channel `ch` is at `[ch*N +: N]`.
- `en_in`  in  1  pixel valid; the pixel is accepted on every cycle `en_in`=1 (no backpressure).
- `sof`  in  1  start of frame; qualified by `en_in`; forces the accepted pixel to be position (0,0).
- `data2conv`  out  `CL_IN*KERNEL*KERNEL*N`  window; element `i = ch*K*K + r*K + c` at `[i*N +: N]`.
  - `r`=0 is the top (oldest) row; `c`=0 is the leftmost (oldest) column.
- `en_out`  out  1  `data2conv` is valid this cycle (one-cycle pulse per window).
- `last_out`  out  1  marks the final window of the frame; coincides with `en_out`.

## Operation
- **Position counters.** `col` runs 0..`IMG_W-1` and `row` runs 0..`IMG_H-1`. They track the position of the next pixel to be accepted.
  - On acceptance: `col`++. At `IMG_W-1`, `col` wraps to 0 and `row`++. At (`IMG_H-1`, `IMG_W-1`), both wrap to 0.
  - Accepted pixel with `sof`=1: the pixel is treated as (0,0) and the counters become (0,1). A mid-frame `sof` abandons the partial frame.
- **Line buffers.** `KERNEL-1` row-delay FIFOs in a cascade, each `IMG_W` deep and `CL_IN*N` wide. On each accepted pixel, all buffers shift once.
  - Buffer `k` output is the pixel from `k+1` rows earlier at the same column.
- **Window register.** `KERNEL` rows × `KERNEL` columns × `CL_IN` channels. On acceptance, every row shifts left by one column.
  - The new rightmost column is filled top to bottom with: oldest line-buffer output, …, buffer 0 output, then `d_in`.
- **Window valid condition.** A window is emitted for an accepted pixel at (`row`,`col`) when `row` ≥ `KERNEL-1` and `col` ≥ `KERNEL-1`. Under this condition the window contents are entirely from the current frame, so buffer contents are never exposed otherwise.
- **Window count.** Exactly `(IMG_H-KERNEL+1)*(IMG_W-KERNEL+1)` windows per frame.
- **Last window.** `last_out`=1 for the window of pixel (`IMG_H-1`,`IMG_W-1`).
- **Idle cycles.** When `en_in`=0, nothing shifts, counters hold, `en_out`=0, and `data2conv` holds its last value.
- **`KERNEL`=1.** No line buffers. `data2conv` = `d_in` registered, and `en_out` fires for every accepted pixel.
- **Arithmetic.** Pure data movement; no arithmetic on samples, and widths are preserved.

## Timing
- **Latency.** Registered outputs: `en_out`/`data2conv`/`last_out` appear one cycle after the accepting edge of the window's bottom-right pixel.
- **Throughput.** One window per cycle at sustained `en_in`=1.
- **Frames.** Back-to-back frames need no gap cycles. Across the wrap, columns 0..`KERNEL-2` of every row produce no window.
- **Reset values.** `data2conv`=0, `en_out`=0, `last_out`=0, `col`=`row`=0.
  - Line buffer and window storage are not cleared; this is safe because of the valid gating.
- **`rst` priority.** `rst` overrides `en_in`/`sof` in the same cycle.
- **Reset mid-frame.** The partial frame is discarded, and the next accepted pixel is (0,0).

## Structure
- Shared package `conv_pkg`:
  - `KERNEL` legality check (1/3/5/7).
  - Window index function `win_idx(ch,r,c) = ch*K*K + r*K + c`.
  - The `E1`/`E2` growth constants already used for `CE` output width, so both blocks agree.
- Sub-module `line_buffer` (params `DEPTH`=`IMG_W`, `WIDTH`=`CL_IN*N`; ports `clk`, `rst`, `en`, `d_in`, `d_out`).
  - Circular RAM with one pointer that wraps at `DEPTH-1`.
  - Instantiated `KERNEL-1` times.

## Test plan
Default bench parameters: `CL_IN`=2, `KERNEL`=3, `N`=4, `IMG_W`=5, `IMG_H`=4. Stimulus for every scenario: ch0 = `(row*5+col) mod 16`, ch1 = ch0+1.

- **Full frame.** Continuous 20 pixels, `sof` on the first → 6 windows.
  - First window appears the cycle after pixel 12: element (ch0,0,0)=0, (ch0,2,2)=12, (ch1,0,0)=1.
  - Sixth window has (ch0,0,0)=7 with `last_out`=1.
- **Throttled input.** `en_in` toggled 1/0 each cycle → the same 6 windows with identical data. `en_out` fires only on cycles following an accepted pixel, and outputs hold through gaps.
- **Back-to-back frames.** Two consecutive frames → 12 windows; the second frame's first window follows its pixel 12, with no window for columns 0–1.
- **Mid-frame `sof`.** `sof` asserted on accepted pixel 8 → no `en_out` until 12 pixels after it; then (ch0,0,0)=8.
- **Reset mid-frame.** `rst` pulsed for 1 cycle mid-frame → outputs 0 next cycle; the restarted frame yields the scenario-1 results exactly.
- **`KERNEL`=1.** Rebuild with `KERNEL`=1 → `en_out` for every accepted pixel, `data2conv` = previous `d_in`, and `last_out` on pixel 19.
